// File: rtl/video_reg_bank.sv
// LCD register bank: N byte registers on the CPU bus, LY line counter, LY==LYC coincidence IRQ.
// Optional macro VREG_SHADOW_EN: reg_q is driven from per-line shadow copies instead of the live regs.
module video_reg_bank #(
  parameter int DATA_W   = 8,
  parameter int N_REGS   = 12,
  parameter int ADDR_W   = 4,
  parameter int LY_IDX   = 4,
  parameter int LYC_IDX  = 5,
  parameter int LINE_MAX = 153
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic                     cpu_rd,
  input  logic                     cpu_wr,
  input  logic [DATA_W-1:0]        cpu_din,
  output logic [DATA_W-1:0]        cpu_dout,
  output logic                     cpu_dout_en,
  input  logic                     line_tick,
  output logic [N_REGS*DATA_W-1:0] reg_q,
  output logic [DATA_W-1:0]        ly,
  output logic                     lyc_match,
  output logic                     lyc_irq
);

  localparam logic [ADDR_W:0]   N_REGS_A   = (ADDR_W+1)'(N_REGS);
  localparam logic [ADDR_W-1:0] LY_A       = ADDR_W'(LY_IDX);
  localparam logic [DATA_W-1:0] LINE_MAX_D = DATA_W'(LINE_MAX);

  logic [DATA_W-1:0] regs_q [N_REGS];
  logic [DATA_W-1:0] regs_d [N_REGS];
  logic [DATA_W-1:0] view   [N_REGS];
  logic [DATA_W-1:0] ly_q, ly_d;
  logic              lyc_match_q, lyc_match_d;
  logic              lyc_irq_q, lyc_irq_d;
  logic              addr_ok, ly_sel;

  assign addr_ok = {1'b0, cpu_addr} < N_REGS_A;
  assign ly_sel  = (cpu_addr == LY_A);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    regs_d = regs_q;
    ly_d   = ly_q;
    if (cpu_wr && addr_ok && !ly_sel) regs_d[cpu_addr] = cpu_din;
    if (line_tick) ly_d = (ly_q == LINE_MAX_D) ? '0 : ly_q + 1'b1;
    // An LY write clears the counter and beats a simultaneous tick.
    if (cpu_wr && ly_sel) ly_d = '0;
    lyc_match_d = (ly_q == regs_q[LYC_IDX]);
    lyc_irq_d   = lyc_match_d && !lyc_match_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the register array is cleared by reset because software expects zeroed registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
      ly_q        <= '0;
      lyc_match_q <= 1'b0;
      lyc_irq_q   <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      ly_q        <= ly_d;
      lyc_match_q <= lyc_match_d;
      lyc_irq_q   <= lyc_irq_d;
    end
  end

`ifdef VREG_SHADOW_EN
  logic [DATA_W-1:0] shadow_q [N_REGS];
  logic [DATA_W-1:0] shadow_d [N_REGS];

  // Loading from regs_d makes a write on a tick cycle land in the shadow too.
  always_comb begin
    shadow_d = shadow_q;
    if (line_tick) shadow_d = regs_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) shadow_q[i] <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  always_comb view = shadow_q;
`else
  always_comb view = regs_q;
`endif

  // The LY slot has no storage; it carries the live line counter.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < N_REGS; i++)
      reg_q[i*DATA_W +: DATA_W] = (i == LY_IDX) ? ly_q : view[i];
  end

  assign cpu_dout_en = cpu_rd && addr_ok;
  assign cpu_dout    = !cpu_dout_en ? '0 : (ly_sel ? ly_q : regs_q[cpu_addr]);
  assign ly          = ly_q;
  assign lyc_match   = lyc_match_q;
  assign lyc_irq     = lyc_irq_q;

endmodule

// File: tb/tb_video_reg_bank.sv
// Directed self-checking bench for video_reg_bank with hand-computed expectations.
// Shadow-mode checks compile in only when VREG_SHADOW_EN is defined.
module tb_video_reg_bank;

  localparam int DATA_W = 8;
  localparam int N_REGS = 12;
  localparam int ADDR_W = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [ADDR_W-1:0]        cpu_addr;
  logic                     cpu_rd;
  logic                     cpu_wr;
  logic [DATA_W-1:0]        cpu_din;
  logic [DATA_W-1:0]        cpu_dout;
  logic                     cpu_dout_en;
  logic                     line_tick;
  logic [N_REGS*DATA_W-1:0] reg_q;
  logic [DATA_W-1:0]        ly;
  logic                     lyc_match;
  logic                     lyc_irq;

  int n_vec = 0;
  int n_err = 0;

  video_reg_bank dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_din     (cpu_din),
    .cpu_dout    (cpu_dout),
    .cpu_dout_en (cpu_dout_en),
    .line_tick   (line_tick),
    .reg_q       (reg_q),
    .ly          (ly),
    .lyc_match   (lyc_match),
    .lyc_irq     (lyc_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cpu_wr   = 1'b1;
    cpu_addr = a;
    cpu_din  = d;
    step();
    cpu_wr   = 1'b0;
  endtask

  task automatic tick();
    line_tick = 1'b1;
    step();
    line_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_din = '0; line_tick = 1'b0;
    step(); step();
    check("rst_ly", 32'(ly), 32'd0);
    check("rst_match", 32'(lyc_match), 32'd0);
    check("rst_irq", 32'(lyc_irq), 32'd0);

    // First edge out of reset: ly=0 equals LYC=0, so match and a single irq pulse.
    reset = 1'b0;
    step();
    check("rel_match", 32'(lyc_match), 32'd1);
    check("rel_irq", 32'(lyc_irq), 32'd1);
    step();
    check("rel_irq_drop", 32'(lyc_irq), 32'd0);
    check("rel_match_hold", 32'(lyc_match), 32'd1);

    cpu_rd = 1'b1;
    for (int i = 0; i < N_REGS; i++) begin
      cpu_addr = ADDR_W'(i);
      #1;
      check($sformatf("rd_rst_dout%0d", i), 32'(cpu_dout), 32'd0);
      check($sformatf("rd_rst_en%0d", i), 32'(cpu_dout_en), 32'd1);
    end
    cpu_addr = 4'd15;
    #1;
    check("rd15_en", 32'(cpu_dout_en), 32'd0);
    check("rd15_dout", 32'(cpu_dout), 32'd0);

    // Read and write in the same cycle returns the pre-edge value.
    cpu_addr = 4'd2; cpu_din = 8'hA5; cpu_wr = 1'b1;
    #1;
    check("rdwr_pre", 32'(cpu_dout), 32'd0);
    step();
    cpu_wr = 1'b0;
    check("rd2_post", 32'(cpu_dout), 32'hA5);
`ifndef VREG_SHADOW_EN
    check("regq2_live", 32'(reg_q[23:16]), 32'hA5);
`endif
    // Out-of-range write leaves the bank untouched.
    wr_reg(4'd13, 8'h5A);
    cpu_addr = 4'd2;
    #1;
    check("oor_wr_keep2", 32'(cpu_dout), 32'hA5);
    cpu_rd = 1'b0;
    #1;
    check("rd_off_dout", 32'(cpu_dout), 32'd0);

    // Full frame: 154 ticks walk ly 1..153 then wrap to 0.
    for (int k = 1; k <= 154; k++) begin
      tick();
      check($sformatf("ly_tick%0d", k), 32'(ly), (k == 154) ? 32'd0 : 32'(k));
    end
    for (int k = 0; k < 10; k++) tick();
    check("ly_at10", 32'(ly), 32'd10);
    cpu_rd = 1'b1; cpu_addr = 4'd4;
    #1;
    check("rd_ly", 32'(cpu_dout), 32'd10);
    cpu_rd = 1'b0;
    line_tick = 1'b1;
    wr_reg(4'd4, 8'hFF);
    line_tick = 1'b0;
    check("ly_clear_wins", 32'(ly), 32'd0);

    // Coincidence: LYC=3, walk ly to 3.
    wr_reg(4'd5, 8'd3);
    step();
    check("lyc3_nomatch", 32'(lyc_match), 32'd0);
    tick(); tick(); tick();
    check("ly3", 32'(ly), 32'd3);
    check("ly3_match_lag", 32'(lyc_match), 32'd0);
    step();
    check("ly3_match", 32'(lyc_match), 32'd1);
    check("ly3_irq", 32'(lyc_irq), 32'd1);
    step();
    check("ly3_irq_once", 32'(lyc_irq), 32'd0);
    check("ly3_match_hold", 32'(lyc_match), 32'd1);
    step();
    check("ly3_no_repeat", 32'(lyc_irq), 32'd0);

    wr_reg(4'd5, 8'd3);
    check("rewr_irq_a", 32'(lyc_irq), 32'd0);
    step();
    check("rewr_irq_b", 32'(lyc_irq), 32'd0);

    wr_reg(4'd5, 8'd7);
    check("lyc7_match_lag", 32'(lyc_match), 32'd1);
    wr_reg(4'd5, 8'd3);
    check("lyc7_match_drop", 32'(lyc_match), 32'd0);
    check("lyc7_irq", 32'(lyc_irq), 32'd0);
    step();
    check("lyc3_again_match", 32'(lyc_match), 32'd1);
    check("lyc3_again_irq", 32'(lyc_irq), 32'd1);
    step();
    check("lyc3_again_drop", 32'(lyc_irq), 32'd0);

    // Reset on the edge that would have fired an irq drops it.
    wr_reg(4'd5, 8'd5);
    tick(); tick();
    check("ly5", 32'(ly), 32'd5);
    reset = 1'b1;
    step();
    check("midrst_ly", 32'(ly), 32'd0);
    check("midrst_irq", 32'(lyc_irq), 32'd0);
    check("midrst_match", 32'(lyc_match), 32'd0);
    check("midrst_reg2", 32'(reg_q[23:16]), 32'd0);
    reset = 1'b0;
    step();
    check("midrst_rel_irq", 32'(lyc_irq), 32'd1);
    step();

    wr_reg(4'd3, 8'h11);
`ifdef VREG_SHADOW_EN
    check("shadow_hold", 32'(reg_q[31:24]), 32'd0);
    step();
    check("shadow_hold2", 32'(reg_q[31:24]), 32'd0);
    tick();
    check("shadow_load", 32'(reg_q[31:24]), 32'h11);
    line_tick = 1'b1;
    wr_reg(4'd3, 8'h22);
    line_tick = 1'b0;
    check("shadow_wthru", 32'(reg_q[31:24]), 32'h22);
    cpu_rd = 1'b1; cpu_addr = 4'd3;
    #1;
    check("shadow_rd_live", 32'(cpu_dout), 32'h22);
    cpu_rd = 1'b0;
`else
    check("live_reg3", 32'(reg_q[31:24]), 32'h11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
